// File: rtl/cache_pkg.sv
// Shared cache-subsystem types and line-geometry constants used by the memory arbiter.
package cache_pkg;

  localparam int unsigned WORDS_PER_LINE = 8;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} arb_state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_I, OWN_D} owner_t;

  // Byte-offset bits inside a line of 16-bit words.
  function automatic int unsigned line_off_w(input int unsigned words);
    return $clog2(words) + 1;
  endfunction

  localparam int unsigned LINE_OFF_W = line_off_w(WORDS_PER_LINE);

endpackage

// File: rtl/arb_fill_counter.sv
// Issue/return word counters for a line fill, with terminal-count flags.
module arb_fill_counter #(
  parameter int unsigned WORDS_PER_LINE = 8,
  localparam int unsigned IDX_W = $clog2(WORDS_PER_LINE)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             issue_inc,
  input  logic             ret_inc,
  output logic [IDX_W-1:0] issue_idx,
  output logic [IDX_W-1:0] ret_idx,
  output logic             issue_done,
  output logic             ret_done
);

  localparam logic [IDX_W:0] TERM = (IDX_W + 1)'(WORDS_PER_LINE);

  logic [IDX_W:0] issue_cnt, ret_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      issue_cnt <= '0;
      ret_cnt   <= '0;
    end else begin
      if (issue_inc && !issue_done) issue_cnt <= issue_cnt + 1'b1;
      if (ret_inc && !ret_done)     ret_cnt   <= ret_cnt + 1'b1;
    end
  end

  assign issue_done = (issue_cnt == TERM);
  assign ret_done   = (ret_cnt == TERM);
  assign issue_idx  = issue_cnt[IDX_W-1:0];
  assign ret_idx    = ret_cnt[IDX_W-1:0];

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates main memory between I-cache fills and D-cache fills/write-throughs.
// Define ARB_ROUND_ROBIN_EN to alternate I/D fill priority (write-through stays on top).
module mem_arbiter
  import cache_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = cache_pkg::WORDS_PER_LINE,
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned DATA_W = 16,
  localparam int unsigned WORD_IDX_W = $clog2(WORDS_PER_LINE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_req,
  input  logic [ADDR_W-1:0]     i_addr,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [ADDR_W-1:0]     d_addr,
  input  logic [DATA_W-1:0]     d_wdata,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_wdata,
  input  logic [DATA_W-1:0]     mem_rdata,
  input  logic                  mem_rvalid,
  output logic [DATA_W-1:0]     fill_data,
  output logic [WORD_IDX_W-1:0] fill_word,
  output logic                  fill_wen_i,
  output logic                  fill_wen_d,
  output logic                  i_done,
  output logic                  d_done,
  output logic                  busy
);

  localparam int unsigned OFF_W = line_off_w(WORDS_PER_LINE);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((1 << OFF_W) - 1);

  arb_state_t state_q, state_d;
  owner_t owner_q, owner_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [DATA_W-1:0] fill_data_q;
  logic [WORD_IDX_W-1:0] fill_word_q;
  logic wen_i_q, wen_d_q;

  logic [WORD_IDX_W-1:0] issue_idx, ret_idx;
  logic issue_done, ret_done;
  logic in_fill, issue_go, ret_go, pick_d_fill;

  assign in_fill  = (state_q == FILL);
  assign issue_go = in_fill & ~issue_done;
  assign ret_go   = in_fill & mem_rvalid & ~ret_done;

`ifdef ARB_ROUND_ROBIN_EN
  logic pref_i_q;

  // Flip fill preference to the other side once a fill finishes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pref_i_q <= 1'b0;
    end else if (in_fill && ret_done) begin
      pref_i_q <= (owner_q == OWN_D);
    end
  end

  assign pick_d_fill = d_req & ~d_wr & ~(pref_i_q & i_req);
`else
  assign pick_d_fill = d_req & ~d_wr;
`endif

  arb_fill_counter #(
    .WORDS_PER_LINE(WORDS_PER_LINE)
  ) u_cnt (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state_q == DONE),
    .issue_inc (issue_go),
    .ret_inc   (ret_go),
    .issue_idx (issue_idx),
    .ret_idx   (ret_idx),
    .issue_done(issue_done),
    .ret_done  (ret_done)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    base_d  = base_q;
    case (state_q)
      IDLE: begin
        if (d_req && d_wr) begin
          state_d = WRITE;
          owner_d = OWN_D;
        end else if (pick_d_fill) begin
          state_d = FILL;
          owner_d = OWN_D;
          base_d  = d_addr & ~LINE_MASK;
        end else if (i_req) begin
          state_d = FILL;
          owner_d = OWN_I;
          base_d  = i_addr & ~LINE_MASK;
        end
      end
      WRITE:   state_d = DONE;
      FILL:    if (ret_done) state_d = DONE;
      DONE: begin
        state_d = IDLE;
        owner_d = OWN_NONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= OWN_NONE;
      base_q      <= '0;
      fill_data_q <= '0;
      fill_word_q <= '0;
      wen_i_q     <= 1'b0;
      wen_d_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      base_q  <= base_d;
      wen_i_q <= ret_go & (owner_q == OWN_I);
      wen_d_q <= ret_go & (owner_q == OWN_D);
      if (ret_go) begin
        fill_data_q <= mem_rdata;
        fill_word_q <= ret_idx;
      end
    end
  end

  // Base has its offset bits cleared, so OR-ing the word offset never carries into the tag.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (state_q == WRITE) begin
      mem_en    = 1'b1;
      mem_wr    = 1'b1;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (issue_go) begin
      mem_en   = 1'b1;
      mem_addr = base_q | ADDR_W'({issue_idx, 1'b0});
    end
  end

  assign fill_data  = fill_data_q;
  assign fill_word  = fill_word_q;
  assign fill_wen_i = wen_i_q;
  assign fill_wen_d = wen_d_q;
  assign i_done     = (state_q == DONE) && (owner_q == OWN_I);
  assign d_done     = (state_q == DONE) && (owner_q == OWN_D);
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: fixed-latency memory model plus a transaction-timing reference.
module tb_mem_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic i_req = 1'b0, d_req = 1'b0, d_wr = 1'b0;
  logic [15:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic mem_en, mem_wr, mem_rvalid = 1'b0;
  logic [15:0] mem_addr, mem_wdata, mem_rdata = '0, fill_data;
  logic [2:0] fill_word;
  logic fill_wen_i, fill_wen_d, i_done, d_done, busy;

  always #5 clk = ~clk;

  mem_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_req     (i_req),
    .i_addr    (i_addr),
    .d_req     (d_req),
    .d_wr      (d_wr),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .mem_en    (mem_en),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_rvalid(mem_rvalid),
    .fill_data (fill_data),
    .fill_word (fill_word),
    .fill_wen_i(fill_wen_i),
    .fill_wen_d(fill_wen_d),
    .i_done    (i_done),
    .d_done    (d_done),
    .busy      (busy)
  );

  typedef struct {int due; logic [15:0] d;} rd_t;
  rd_t pend[$];

  int cyc = 0, checks = 0, errors = 0, mem_lat = 4;
  logic [15:0] salt = '0;
  bit force_rv = 1'b0;

  // Reference model: one transaction at a time, timed relative to its grant cycle.
  bit has_txn = 1'b0, idle_last = 1'b1, m_wr = 1'b0, m_d = 1'b0, pref_i = 1'b0;
  int g = 0, lat = 0, last_fw = 0;
  logic [15:0] base = '0, w_addr = '0, w_data = '0, last_fd = '0;

  function automatic logic [15:0] memf(input logic [15:0] a);
    return (a * 16'h9E37) ^ salt;
  endfunction

  function automatic logic [15:0] line_base(input logic [15:0] a);
    return a - (a % 16'd16);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle %0d: got %h expected %h", tag, cyc, obs, exp);
    end
  endtask

  task automatic step();
    int k;
    logic e_en, e_wr, e_wi, e_wd, e_id, e_dd, e_busy;
    logic [15:0] e_addr, e_wdata, o_addr, o_wdata;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      has_txn = 1'b0; idle_last = 1'b1; pref_i = 1'b0; last_fd = '0; last_fw = 0;
    end else if (idle_last && (i_req || d_req)) begin
      g = cyc - 1; has_txn = 1'b1; lat = mem_lat;
      if (d_req && d_wr) begin
        m_wr = 1'b1; m_d = 1'b1; w_addr = d_addr; w_data = d_wdata;
      end else if (d_req && !(RR && pref_i && i_req)) begin
        m_wr = 1'b0; m_d = 1'b1; base = line_base(d_addr);
      end else begin
        m_wr = 1'b0; m_d = 1'b0; base = line_base(i_addr);
      end
    end
    {e_en, e_wr, e_wi, e_wd, e_id, e_dd, e_busy} = '0;
    e_addr = '0; e_wdata = '0;
    if (has_txn) begin
      k = cyc - g;
      if (m_wr) begin
        e_busy = (k <= 2);
        if (k == 1) begin e_en = 1; e_wr = 1; e_addr = w_addr; e_wdata = w_data; end
        if (k == 2) e_dd = 1;
      end else begin
        e_busy = (k <= 10 + lat);
        if (k >= 1 && k <= 8) begin e_en = 1; e_addr = base + 16'(2 * (k - 1)); end
        if (k >= 2 + lat && k <= 9 + lat) begin
          if (m_d) e_wd = 1; else e_wi = 1;
          last_fw = k - 2 - lat;
          last_fd = memf(base + 16'(2 * last_fw));
        end
        if (k == 10 + lat) begin
          if (m_d) e_dd = 1; else e_id = 1;
          pref_i = !m_d;
        end
      end
      idle_last = 1'b0;
      if (k == (m_wr ? 2 : 10 + lat)) has_txn = 1'b0;
    end else begin
      idle_last = 1'b1;
    end
    o_addr  = e_en ? mem_addr : '0;
    o_wdata = (e_en && e_wr) ? mem_wdata : '0;
    chk("outputs",
        {mem_en, mem_wr, o_addr, o_wdata, fill_data, fill_word, fill_wen_i, fill_wen_d,
         i_done, d_done, busy},
        {e_en, e_wr, e_addr, e_wdata, last_fd, 3'(last_fw), e_wi, e_wd, e_id, e_dd, e_busy});
    // Memory: in-order returns, fixed latency per issue.
    mem_rvalid = 1'b0;
    while (pend.size() > 0 && pend[0].due < cyc) void'(pend.pop_front());
    if (pend.size() > 0 && pend[0].due == cyc) begin
      mem_rvalid = 1'b1; mem_rdata = pend[0].d; void'(pend.pop_front());
    end
    if (force_rv) begin mem_rvalid = 1'b1; mem_rdata = 16'($urandom); end
    if (mem_en && !mem_wr) pend.push_back('{due: cyc + mem_lat, d: memf(mem_addr)});
    if (i_done) i_req = 1'b0;
    if (d_done) begin d_req = 1'b0; d_wr = 1'b0; end
  endtask

  task automatic tick(input int n);
    repeat (n) step();
  endtask

  task automatic wait_idle(input int bound);
    bit ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      step();
      if (!i_req && !d_req && !has_txn && pend.size() == 0) begin ok = 1'b1; break; end
    end
    checks++;
    assert (ok) else begin
      errors++;
      $error("FAIL idle_timeout cycle %0d: got busy expected idle within %0d", cyc, bound);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk(tag, {mem_en, mem_wr, mem_addr, mem_wdata, fill_data, fill_word, fill_wen_i,
              fill_wen_d, i_done, d_done, busy}, 64'd0);
  endtask

  initial begin
    salt = 16'($urandom);
    tick(3);
    chk_zero("reset_out");
    rst_n = 1'b1;
    tick(2);

    // Single I fill, L=4, mid-line address.
    mem_lat = 4; i_addr = 16'h0036; i_req = 1'b1;
    wait_idle(60);

    // Simultaneous I and D fill requests.
    mem_lat = 3; i_addr = 16'h0410; d_addr = 16'h1204; d_wr = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    wait_idle(100);

    // D fill alone, then contention again (preference flips under round-robin).
    d_addr = 16'h3008; d_req = 1'b1;
    wait_idle(60);
    i_addr = 16'h0522; d_addr = 16'h1236; i_req = 1'b1; d_req = 1'b1;
    wait_idle(100);

    // Write-through beats a pending I fill.
    mem_lat = 2; i_addr = 16'h0100; d_addr = 16'h2002; d_wdata = 16'hBEEF;
    i_req = 1'b1; d_req = 1'b1; d_wr = 1'b1;
    wait_idle(60);

    // Top-of-memory line stays inside the line.
    mem_lat = 5; i_addr = 16'hFFFA; i_req = 1'b1;
    wait_idle(60);

    // Reset in cycle 5 of a fill, stray returns afterwards, then a fresh fill.
    mem_lat = 4; i_addr = 16'h0248; i_req = 1'b1;
    tick(6);
    rst_n = 1'b0; i_req = 1'b0;
    step();
    chk_zero("mid_reset_out");
    rst_n = 1'b1;
    wait_idle(40);
    i_addr = 16'h0104; i_req = 1'b1;
    wait_idle(60);

    // Unsolicited rvalid while idle.
    force_rv = 1'b1;
    step();
    force_rv = 1'b0;
    tick(3);

    for (int n = 0; n < 25; n++) begin
      mem_lat = int'($urandom_range(1, 6));
      i_addr  = 16'($urandom);
      d_addr  = 16'($urandom);
      d_wdata = 16'($urandom);
      d_wr    = 1'($urandom_range(0, 1));
      i_req   = 1'($urandom_range(0, 1));
      d_req   = 1'($urandom_range(0, 1));
      if (!i_req && !d_req) i_req = 1'b1;
      if (!d_req) d_wr = 1'b0;
      wait_idle(200);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single multi-cycle main memory between the I-cache miss path and the D-cache miss/write-through path of the pipelined CPU.
- Sequences 8-word line fills: one address issue per cycle, returning words steered to the granted cache.
- Also issues single-word D-side write-throughs.
- Sits between the two cache controllers and the memory wrapper; the hazard unit stalls the pipeline on `busy`.

Parameters:
- WORDS_PER_LINE, 8: words per cache line; power of 2.
- ADDR_W, 16: byte-address width.
- DATA_W, 16: word width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- i_req  in  1  I-cache miss request; held high until i_done
- i_addr  in  ADDR_W  I-side miss byte address (any word in line)
- d_req  in  1  D-side request; held high until d_done
- d_wr  in  1  with d_req: 1 = single-word write-through, 0 = line fill
- d_addr  in  ADDR_W  D-side byte address
- d_wdata  in  DATA_W  write-through data
- mem_en  out  1  memory access strobe
- mem_wr  out  1  write strobe (valid with mem_en)
- mem_addr  out  ADDR_W  memory byte address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data
- mem_rvalid  in  1  mem_rdata valid; in-order, fixed latency
- fill_data  out  DATA_W  returned word (registered copy of mem_rdata)
- fill_word  out  log2(WORDS_PER_LINE)  word index within line
- fill_wen_i  out  1  write fill_data into I-cache data array
- fill_wen_d  out  1  write fill_data into D-cache data array
- i_done  out  1  one-cycle pulse: I fill complete
- d_done  out  1  one-cycle pulse: D fill or write complete
- busy  out  1  state != IDLE

Behaviour:
- Reset: all outputs 0. State IDLE, counters 0, owner none. Reset mid-transaction aborts it; no done is pulsed.
- States: IDLE, WRITE, FILL, DONE.
- IDLE priority (fixed): d_req&d_wr > d_req&!d_wr > i_req.
  - Winner is latched as owner.
  - Line base = addr with low log2(WORDS_PER_LINE)+1 bits cleared, captured at grant.
  - Winner is write -> WRITE; winner is fill -> FILL.
- WRITE (1 cycle): mem_en=mem_wr=1, mem_addr=d_addr, mem_wdata=d_wdata -> DONE.
- FILL: while issue_cnt < WORDS_PER_LINE:
  - mem_en=1, mem_wr=0, mem_addr = base + 2*issue_cnt; issue_cnt++.
  - Addresses stay inside the line; no carry into the tag bits (base 0xFFF0 issues 0xFFF0..0xFFFE).
  - Each cycle with mem_rvalid: fill_data <= mem_rdata, fill_word <= ret_cnt, owner's fill_wen pulses next cycle, ret_cnt++.
  - ret_cnt reaching WORDS_PER_LINE -> DONE.
- DONE (1 cycle): owner's done pulses; counters cleared -> IDLE.
- Requester must deassert req in the cycle after done; a req still high in IDLE starts a new transaction.
- Latency (memory latency L): grant cycle 0; issues cycles 1..8; rvalid cycles 1+L..8+L; last fill_wen 9+L; done 10+L.
  - Write: mem_en cycle 1, done cycle 2.
- mem_rvalid outside FILL is ignored.
- Requests arriving while busy wait; grant is only evaluated in IDLE. Dropping req mid-transaction does not abort.
- Simultaneous i_req and d_req fill: D served first, I granted in the IDLE cycle after d_done.
- fill_wen_i and fill_wen_d are never both 1.

Optional Feature:
- ARB_ROUND_ROBIN_EN
- Defined: fill arbitration alternates. After an I fill completes, D is preferred; after a D fill, I is preferred. Write-through still has top priority. Prevents I-side starvation under back-to-back D misses.
- Undefined: fixed D-over-I priority as above.

Decomposition:
- Shared package (cache_pkg): arb_state_t enum {IDLE, WRITE, FILL, DONE}, owner_t enum {OWN_NONE, OWN_I, OWN_D}, WORDS_PER_LINE, line-offset width constant.
- One sub-module is natural: arb_fill_counter, holding issue_cnt/ret_cnt with terminal-count flags.
- FSM and priority logic stay in mem_arbiter.

Test Plan:
- i_req, i_addr=0x0036, L=4 -> mem_addr 0x0030..0x003E on cycles 1-8. fill_wen_i with fill_word 0..7 on cycles 6-13. i_done cycle 14. fill_wen_d never asserts.
- i_req and d_req (fill, d_addr=0x1204) same cycle -> D fill of 0x1200..0x120E first; I fill begins right after d_done. With ARB_ROUND_ROBIN_EN and a prior D fill, the I fill goes first.
- d_req&d_wr, d_addr=0x2002, d_wdata=0xBEEF, while i_req pending -> write granted first: mem_en=mem_wr=1, addr 0x2002, data 0xBEEF, one cycle. d_done cycle 2, then I fill starts.
- i_addr=0xFFFA -> issued addresses 0xFFF0..0xFFFE, no wrap to 0x0000.
- rst_n low at cycle 5 of a fill -> next cycle all outputs 0 and busy=0. Stray mem_rvalid then produces no fill_wen. A fresh request after reset starts at word 0.
- mem_rvalid pulsed in IDLE -> no fill_wen and no done.
